// File: rtl/tm1638_hienthi.sv
// tm1638_hienthi: refreshes a TM1638 board with 8 BCD digits, dots, LEDs and brightness over STB/CLK/DIO
module tm1638_hienthi #(
  parameter int CLK_DIV = 25
) (
  input  logic        clk,
  input  logic        rs,
  input  logic [31:0] so,
  input  logic [7:0]  dp,
  input  logic [7:0]  led,
  input  logic [2:0]  do_sang,
  input  logic        bat,
  output logic        stb,
  output logic        tm_clk,
  output logic        dio,
  output logic        xong
);
  typedef enum logic [1:0] {NAP, GUI, NGHI} state_t;
  state_t       r_st;
  logic [7:0]   r_div;
  logic         r_ph;
  logic [7:0]   r_bit;
  logic [1:0]   r_cmd;
  logic [31:0]  r_so;
  logic [7:0]   r_dp;
  logic [7:0]   r_led;
  logic [2:0]   r_sang;
  logic         r_bat;
  logic [135:0] w_c2;
  logic [135:0] w_vec;
  logic [1:0]   w_sel;
  logic [7:0]   w_idx;
  logic         w_half;
  logic         w_last;
  logic         w_nbit;

  function automatic logic [6:0] seg7(input logic [3:0] b);
    case (b)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // C2 payload in transmit order: address byte, then segment/LED byte pairs per digit
  always_comb begin
    w_c2 = '0;
    w_c2[7:0] = 8'hC0;
    for (int k = 0; k < 8; k++) begin
      w_c2[16*k+8 +: 8]  = {r_dp[7-k], seg7(r_so[31-4*k -: 4])};
      w_c2[16*k+16 +: 8] = {7'd0, r_led[7-k]};
    end
  end

  // during the gap the next command's first bit is preloaded, otherwise the next bit of the current one
  always_comb begin
    w_half = r_div == 8'(CLK_DIV - 1);
    w_last = r_bit == (r_cmd == 2'd1 ? 8'd135 : 8'd7);
    w_sel  = r_st == NGHI ? r_cmd + 2'd1 : r_cmd;
    w_idx  = r_st == GUI ? r_bit + 8'd1 : 8'd0;
    w_vec  = w_sel == 2'd0 ? 136'h40 : w_sel == 2'd1 ? w_c2 : {128'd0, 1'b1, 3'b000, r_bat, r_sang};
    w_nbit = w_vec[w_idx];
  end

  // frame sequencer: snapshot, then three commands each followed by a two-half-period STB-high gap
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      r_st   <= NAP;
      r_div  <= '0;
      r_ph   <= 1'b0;
      r_bit  <= '0;
      r_cmd  <= '0;
      r_so   <= '0;
      r_dp   <= '0;
      r_led  <= '0;
      r_sang <= '0;
      r_bat  <= 1'b0;
      stb    <= 1'b1;
      tm_clk <= 1'b1;
      dio    <= 1'b1;
      xong   <= 1'b0;
    end else begin
      xong <= 1'b0;
      case (r_st)
        NAP: begin
          r_so   <= so;
          r_dp   <= dp;
          r_led  <= led;
          r_sang <= do_sang;
          r_bat  <= bat;
          r_div  <= '0;
          r_ph   <= 1'b0;
          r_st   <= GUI;
          stb    <= 1'b0;
          tm_clk <= 1'b0;
          dio    <= w_nbit;
        end
        GUI: begin
          if (!w_half) r_div <= r_div + 8'd1;
          else begin
            r_div <= '0;
            r_ph  <= ~r_ph;
            if (!r_ph) tm_clk <= 1'b1;
            else if (w_last) begin
              r_st  <= NGHI;
              r_bit <= '0;
              stb   <= 1'b1;
              dio   <= 1'b1;
            end else begin
              r_bit  <= r_bit + 8'd1;
              tm_clk <= 1'b0;
              dio    <= w_nbit;
            end
          end
        end
        NGHI: begin
          if (!w_half) r_div <= r_div + 8'd1;
          else begin
            r_div <= '0;
            r_ph  <= ~r_ph;
            if (r_ph) begin
              if (r_cmd == 2'd2) begin
                r_cmd <= '0;
                r_st  <= NAP;
                xong  <= 1'b1;
              end else begin
                r_cmd  <= r_cmd + 2'd1;
                r_st   <= GUI;
                stb    <= 1'b0;
                tm_clk <= 1'b0;
                dio    <= w_nbit;
              end
            end
          end
        end
        default: r_st <= NAP;
      endcase
    end
  end
endmodule

// File: tb/tb_tm1638_hienthi.sv
// tb_tm1638_hienthi: decodes the serial bus of two instances and checks frames against hand-computed bytes
module tb_tm1638_hienthi;
  logic        clk = 1'b0;
  logic        rs = 1'b0;
  logic [31:0] so;
  logic [7:0]  dp, led;
  logic [2:0]  do_sang;
  logic        bat;
  logic        stb2, tclk2, dio2, xong2;
  logic        stb25, tclk25, dio25, xong25;
  int          pass = 0, total = 0;

  typedef struct {
    logic [31:0]  so;
    logic [7:0]   dp;
    logic [7:0]   led;
    logic         bat;
    logic [2:0]   sang;
    logic [135:0] c2;
    logic [7:0]   c3;
  } vec_t;

  typedef struct {
    logic [135:0] d;
    int           n;
  } cmd_t;

  vec_t         tv[4];
  cmd_t         mq[$];
  int           rq[$];
  logic [135:0] cur_d;
  int           cur_n;
  logic         p_tclk, p_stb;
  int           r25_n;
  logic         p_tclk25, p_stb25;

  always #5 clk = ~clk;

  tm1638_hienthi #(.CLK_DIV(2)) u2 (
    .clk(clk), .rs(rs), .so(so), .dp(dp), .led(led), .do_sang(do_sang), .bat(bat),
    .stb(stb2), .tm_clk(tclk2), .dio(dio2), .xong(xong2)
  );

  tm1638_hienthi #(.CLK_DIV(25)) u25 (
    .clk(clk), .rs(rs), .so(so), .dp(dp), .led(led), .do_sang(do_sang), .bat(bat),
    .stb(stb25), .tm_clk(tclk25), .dio(dio25), .xong(xong25)
  );

  always @(negedge clk) begin
    if (!rs) begin
      cur_n  = 0;
      cur_d  = '0;
      p_tclk = 1'b1;
      p_stb  = 1'b1;
    end else begin
      if (!stb2 && !p_tclk && tclk2 && cur_n < 136) begin
        cur_d[cur_n] = dio2;
        cur_n++;
      end
      if (!p_stb && stb2) begin
        mq.push_back('{d: cur_d, n: cur_n});
        cur_n = 0;
        cur_d = '0;
      end
      p_tclk = tclk2;
      p_stb  = stb2;
    end
  end

  always @(negedge clk) begin
    if (!rs) begin
      r25_n    = 0;
      p_tclk25 = 1'b1;
      p_stb25  = 1'b1;
    end else begin
      if (!stb25 && !p_tclk25 && tclk25) r25_n++;
      if (!p_stb25 && stb25) begin
        rq.push_back(r25_n);
        r25_n = 0;
      end
      p_tclk25 = tclk25;
      p_stb25  = stb25;
    end
  end

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic set_in(input vec_t v);
    so      = v.so;
    dp      = v.dp;
    led     = v.led;
    bat     = v.bat;
    do_sang = v.sang;
  endtask

  task automatic wait_x(input bit sel25, input int lim, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < lim; c++) begin
      @(negedge clk);
      if (sel25 ? xong25 : xong2) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic chk_frame(input string nm, input int base, input logic [135:0] e2, input logic [7:0] e3);
    chk({nm, "_ncmd"}, 136'(mq.size() - base), 136'd3);
    if (mq.size() - base >= 3) begin
      chk({nm, "_c1"}, mq[base].d, 136'h40);
      chk({nm, "_c1n"}, 136'(mq[base].n), 136'd8);
      chk({nm, "_c2"}, mq[base+1].d, e2);
      chk({nm, "_c2n"}, 136'(mq[base+1].n), 136'd136);
      chk({nm, "_c3"}, mq[base+2].d, 136'(e3));
      chk({nm, "_c3n"}, 136'(mq[base+2].n), 136'd8);
    end
  endtask

  initial begin
    bit ok;
    int base, hi, n, rb;
    logic gap_ok;
    tv[0] = '{32'h12345678, 8'h80, 8'h01, 1'b1, 3'd3, 136'h017F0007007D006D0066004F005B0086C0, 8'h8B};
    tv[1] = '{32'hFA000000, 8'h00, 8'h00, 1'b0, 3'd0, 136'h003F003F003F003F003F003F00000000C0, 8'h80};
    tv[2] = '{32'h98765432, 8'h55, 8'hAA, 1'b1, 3'd7, 136'h00DB014F00E6016D00FD010700FF016FC0, 8'h8F};
    tv[3] = '{32'h00000000, 8'hFF, 8'hFF, 1'b0, 3'd5, 136'h01BF01BF01BF01BF01BF01BF01BF01BFC0, 8'h85};
    set_in(tv[0]);
    repeat (3) @(negedge clk);
    chk("rst_out2", 136'({stb2, tclk2, dio2, xong2}), 136'b1110);
    chk("rst_out25", 136'({stb25, tclk25, dio25, xong25}), 136'b1110);
    rs = 1'b1;
    #1;
    chk("stb_before_nap", 136'(stb2), 136'd1);
    @(negedge clk);
    chk("stb_fall", 136'({stb2, tclk2}), 136'b00);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (stb2) begin
        ok = 1'b1;
        break;
      end
    end
    chk("c1_end_wait", 136'(ok), 136'd1);
    hi = 0;
    gap_ok = 1'b1;
    while (stb2 && hi < 20) begin
      if (!tclk2 || !dio2) gap_ok = 1'b0;
      hi++;
      @(negedge clk);
    end
    chk("gap_len", 136'(hi), 136'd4);
    chk("gap_idle", 136'(gap_ok), 136'd1);
    wait_x(1'b0, 700, ok);
    chk("frame0_wait", 136'(ok), 136'd1);
    chk_frame("frame0", 0, tv[0].c2, tv[0].c3);
    for (int i = 0; i < 4; i++) begin
      set_in(tv[i]);
      base = mq.size();
      wait_x(1'b0, 700, ok);
      chk($sformatf("vec%0d_wait", i), 136'(ok), 136'd1);
      chk_frame($sformatf("vec%0d", i), base, tv[i].c2, tv[i].c3);
    end
    so = 32'h00000059; dp = 8'h00; led = 8'h00; bat = 1'b1; do_sang = 3'd0;
    base = mq.size();
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (mq.size() > base && cur_n >= 26) begin
        ok = 1'b1;
        break;
      end
    end
    chk("snap_wait", 136'(ok), 136'd1);
    so = 32'h00000100;
    wait_x(1'b0, 700, ok);
    chk("snap_old_wait", 136'(ok), 136'd1);
    chk_frame("snap_old", base, 136'h006F006D003F003F003F003F003F003FC0, 8'h88);
    base = mq.size();
    wait_x(1'b0, 700, ok);
    chk("snap_new_wait", 136'(ok), 136'd1);
    chk_frame("snap_new", base, 136'h003F003F0006003F003F003F003F003FC0, 8'h88);
    wait_x(1'b1, 8000, ok);
    chk("x25_first", 136'(ok), 136'd1);
    rb = rq.size();
    n = 0;
    ok = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      n++;
      if (xong25) begin
        ok = 1'b1;
        break;
      end
    end
    chk("frame_len25", 136'(n), 136'd7751);
    chk("win25_cnt", 136'(rq.size() - rb), 136'd3);
    if (rq.size() - rb >= 3) chk("win25_rises", 136'({rq[rb][15:0], rq[rb+1][15:0], rq[rb+2][15:0]}), 136'({16'd8, 16'd136, 16'd8}));
    set_in(tv[0]);
    wait_x(1'b0, 700, ok);
    chk("mid_sync", 136'(ok), 136'd1);
    base = mq.size();
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (mq.size() > base && cur_n >= 40) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mid_wait", 136'(ok), 136'd1);
    chk("mid_stb_low", 136'(stb2), 136'd0);
    rs = 1'b0;
    #1;
    chk("mid_rst_out", 136'({stb2, tclk2, dio2, xong2}), 136'b1110);
    repeat (3) @(negedge clk);
    chk("mid_rst_hold", 136'({stb2, tclk2, dio2, xong2}), 136'b1110);
    rs = 1'b1;
    base = mq.size();
    wait_x(1'b0, 700, ok);
    chk("after_rst_wait", 136'(ok), 136'd1);
    chk_frame("after_rst", base, tv[0].c2, tv[0].c3);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/tm1638_hienthi.md
# tm1638_hienthi

Downstream display stage of the TM1638 clock: it consumes the BCD digits produced by the seconds, minutes and hours counters and continuously refreshes the TM1638 board over its 3-wire serial bus (STB/CLK/DIO). Each frame snapshots all inputs, converts the 8 BCD digits to 7-segment codes, and transmits three commands: data-write/auto-increment, address 0xC0 plus 16 data bytes, and display control. The block is write-only and does no key scanning.

## Interface
- CLK_DIV, 25: system clocks per half serial-bit period; 25 gives 1 MHz at 50 MHz. Legal range is 2 to 255.
- clk  in  1  system clock; all logic on its rising edge.
- rs  in  1  asynchronous, active-low reset.
- so  in  32  eight BCD digits; digit k (k=0 leftmost) = so[31-4k -: 4], e.g. so[7:0] = {chuc, donvi} of seconds.
- dp  in  8  decimal point per digit; dp[7-k] drives digit k.
- led  in  8  discrete LEDs; led[7-k] drives LED k.
- do_sang  in  3  brightness level 0..7.
- bat  in  1  display on (1) / off (0).
- stb  out  1  TM1638 STB, active low.
- tm_clk  out  1  TM1638 CLK.
- dio  out  1  TM1638 DIO, push-pull output.
- xong  out  1  one-cycle pulse at end of each frame.

## Operation
- The state machine has three states.
  - NAP (1 cycle): register so/dp/led/do_sang/bat into a snapshot. Input changes after this cycle have no effect until the next frame.
  - GUI: shift out the current command.
  - NGHI: inter-command gap.
- Command sequence per frame:
  - C1 = 1 byte, 0x40.
  - C2 = 17 bytes: 0xC0, then for k=0..7 seg(k), led(k).
  - C3 = 1 byte: 0x80 | bat<<3 | do_sang.
  - Total 152 bits.
- seg(k) = {dp bit, g,f,e,d,c,b,a}. BCD codes:
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66
  - 5→6D, 6→7D, 7→07, 8→7F, 9→6F
  - 10..15 → 00 (blank); the dp bit is still applied.
- led(k) = 0x01 if the LED bit is set, else 0x00.
- Bytes are sent LSB first.
- Transitions:
  - NAP → GUI(C1).
  - GUI, after the last bit → NGHI.
  - NGHI → GUI(next command), or after C3 → NAP with xong=1 for that one cycle.
- Counters:
  - Half-period counter: 8 bits.
  - Bit counter within a command: 0..135.
  - Command index: 0..2.
  - All counters wrap to 0 when they reach their terminal count; no other overflow is possible.
- Reset asserted (rs=0) mid-frame: all outputs return to reset values immediately, the transfer is aborted, and the TM1638 sees STB rise. After release, a full frame restarts from NAP.

## Timing
- Reset values: stb=1, tm_clk=1, dio=1, xong=0, state NAP, all counters 0, snapshot 0.
- The first NAP occurs on the first rising clk edge after rs deasserts.
- Each bit lasts 2·CLK_DIV cycles:
  - Low phase (CLK_DIV cycles): tm_clk=0, with dio updated on entry to the low phase.
  - High phase (CLK_DIV cycles): tm_clk=1, dio held stable.
  - The TM1638 samples dio on the rising edge of tm_clk.
- stb goes low in the same cycle as the first low phase of a command. It stays low through the high phase of the command's last bit and is then high for the whole NGHI gap of 2·CLK_DIV cycles.
- In NAP and NGHI: tm_clk=1 and dio=1.
- Frame length = 1 + 152·2·CLK_DIV + 3·2·CLK_DIV = 1 + 310·CLK_DIV cycles, which is 7751 cycles at CLK_DIV=25.
- xong is asserted exactly once per frame, in the NAP cycle that starts the next frame.

## Test plan
- Reset and first command: hold rs=0 → stb=tm_clk=dio=1, xong=0. Release with CLK_DIV=2 → stb falls 1 cycle later. dio sampled at 8 tm_clk rises reads 0,0,0,0,0,0,1,0 (0x40). stb is then high for 4 cycles.
- Digit decode: so=0x12345678, dp=0x80, led=0x01, bat=1, do_sang=3 → C2 decodes to:
  - C0, 86, 00, 5B, 00, 4F, 00, 66, 00, 6D, 00, 7D, 00, 07, 00, 7F, 01
  - then C3 = 0x8B.
- Invalid BCD: so=0xFA00_0000 → seg(0)=00, seg(1)=00, seg(2..7)=3F.
- Snapshot: change so from 0x00000059 to 0x00000100 while C2 byte 3 is being sent → the current frame still sends 3F/6D/6F for digits 5..7; the next frame sends the new values.
- Frame length and xong: with CLK_DIV=25, measure xong-to-xong = 7751 cycles. Every stb low window contains 8, 136 and 8 tm_clk rising edges respectively.
- Reset mid-frame: assert rs=0 during C2 → outputs equal reset values within the same cycle. After release, the next captured command is 0x40 and the full frame completes.
